rx_receiver: RTL and testbench

//   Serial receive stage. It is the far-end counterpart of tx_transmitter and consumes its tx_line over a

---
 rtl/rx_receiver.sv | 185 ++++++++++++++++++
 tb/tb_rx_receiver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_receiver.sv
// rx_receiver: framed serial deserialiser (start bit, PKT_BITS data bits MSB first, stop bit).
// Publishes each good packet with a one-cycle rx_valid; a low stop bit yields a one-cycle frame_err.
module rx_receiver #(
  parameter int CLKS_PER_BIT = 50,
  parameter int PKT_BITS     = 136
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_line,
  output logic [PKT_BITS-1:0] rx_packet,
  output logic                rx_valid,
  output logic                rx_busy,
  output logic                frame_err,
  output logic [7:0]          pkt_count
);

  // state   | meaning
  // IDLE    | line idle, waiting for a low level on rx_s
  // START   | timing to the middle of the start bit to reject glitches
  // DATA    | sampling PKT_BITS data bits at mid-bit, MSB first
  // STOP    | timing to the middle of the stop bit, then publish or flag
  // WAIT_HI | bad stop bit seen; hold off until the line returns high
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(PKT_BITS + 1);

  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PKT_BITS - 1);

  state_t state;
  state_t state_next;

  logic                rx_meta;
  logic                rx_s;
  logic [CW-1:0]       cyc_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [PKT_BITS-1:0] shift_reg;

  logic cyc_clr;
  logic bit_clr;
  logic shift_en;
  logic load_pkt;
  logic flag_err;
  logic at_half;
  logic at_full;

  assign at_half = (cyc_cnt == HALF_TC);
  assign at_full = (cyc_cnt == FULL_TC);

  // Both flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (at_half) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (at_full && (bit_cnt == LAST_BIT)) state_next = STOP;
      end
      STOP: begin
        if (at_full) state_next = rx_s ? IDLE : WAIT_HI;
      end
      WAIT_HI: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cyc_clr  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    load_pkt = 1'b0;
    flag_err = 1'b0;
    rx_busy  = (state != IDLE);
    unique case (state)
      IDLE: begin
        cyc_clr = 1'b1;
        bit_clr = 1'b1;
      end
      START: begin
        if (at_half) begin
          cyc_clr = 1'b1;
          bit_clr = 1'b1;
        end
      end
      DATA: begin
        if (at_full) begin
          cyc_clr  = 1'b1;
          shift_en = 1'b1;
        end
      end
      STOP: begin
        if (at_full) begin
          cyc_clr  = 1'b1;
          load_pkt = rx_s;
          flag_err = ~rx_s;
        end
      end
      WAIT_HI: begin
        cyc_clr = 1'b1;
      end
      default: begin
        cyc_clr = 1'b1;
        bit_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (cyc_clr) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Left shift so the first bit on the wire ends up in the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[PKT_BITS-2:0], rx_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_packet <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      pkt_count <= '0;
    end else begin
      rx_valid  <= load_pkt;
      frame_err <= flag_err;
      if (load_pkt) begin
        rx_packet <= shift_reg;
        pkt_count <= pkt_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rx_receiver.sv
// Self-checking bench for rx_receiver: drives framed serial traffic and checks against a packet queue model.
// Frame size is reduced so that the 256-packet wrap scenario stays short.
module tb_rx_receiver;
  localparam int CPB   = 8;
  localparam int PB    = 16;
  localparam int LAT   = (PB + 1) * CPB + CPB / 2 + 3;
  localparam int FRAME = (PB + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_line = 1'b1;
  logic [PB-1:0] rx_packet;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic [7:0]    pkt_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_cyc = -1;

  logic [PB-1:0] got_q[$];
  int            got_cyc_q[$];
  logic [PB-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [PB-1:0] last_good = '0;
  int            exp_count = 0;

  rx_receiver #(.CLKS_PER_BIT(CPB), .PKT_BITS(PB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_line   (rx_line),
    .rx_packet (rx_packet),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_packet);
      got_cyc_q.push_back(cyc);
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (rx_valid && frame_err) both_cnt++;
  end

  function automatic logic [PB-1:0] rand_pkt();
    logic [PB-1:0] p;
    for (int i = 0; i < PB; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic logic [PB-1:0] alt_pattern();
    logic [PB-1:0] p = '0;
    for (int j = 0; j < PB / 8; j++) p = (p << 8) | PB'((j % 2 == 0) ? 8'hA5 : 8'h5A);
    p[7:0] = 8'h5A;
    return p;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned (just after a posedge). Good frames are pushed into the model queue.
  task automatic send_frame(input logic [PB-1:0] p, input logic stop, output int s);
    s = cyc;
    drive_bit(1'b0);
    for (int i = PB - 1; i >= 0; i--) drive_bit(p[i]);
    drive_bit(stop);
    if (stop) begin
      exp_q.push_back(p);
      exp_cyc_q.push_back(s + LAT);
      last_good = p;
      exp_count = (exp_count + 1) % 256;
    end
  endtask

  task automatic wait_valids(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && valid_cnt < target; i++) @(posedge clk);
    ok = (valid_cnt >= target);
    align();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rx_packet !== '0) begin n_bad++; $display("FAIL reset_packet: got %h want 0", rx_packet); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (pkt_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", pkt_count); end
    rst_n = 1'b1;
    repeat (4) align();
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int v0, e0, busy_n, g;
    v0 = valid_cnt; e0 = err_cnt; busy_n = 0;
    g = $urandom_range(1, CPB / 2 - 2);
    align();
    rx_line = 1'b0;
    repeat (g) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (4 * CPB) begin
      @(negedge clk);
      if (rx_busy) busy_n++;
    end
    align();
    n_cmp++; if (busy_n < 1 || busy_n > CPB / 2 + 2) begin n_bad++; $display("FAIL glitch_busy: got %0d cycles want 1..%0d", busy_n, CPB / 2 + 2); end
    n_cmp++; if (valid_cnt - v0 != 0) begin n_bad++; $display("FAIL glitch_valid: got %0d pulses want 0", valid_cnt - v0); end
    n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d pulses want 0", err_cnt - e0); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    int s1, s2, v0;
    bit ok;
    logic [PB-1:0] p, e;
    int c, ec;
    v0 = valid_cnt;
    got_q.delete(); got_cyc_q.delete();
    send_frame('1, 1'b1, s1);
    send_frame('0, 1'b1, s2);
    wait_valids(v0 + 2, 2 * FRAME + LAT, ok);
    n_cmp++; if (!ok || valid_cnt - v0 != 2) begin n_bad++; $display("FAIL b2b_count: got %0d pulses want 2", valid_cnt - v0); end
    n_cmp++;
    if (got_cyc_q.size() < 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d pulses want spacing %0d", got_cyc_q.size(), FRAME); end
    else if (got_cyc_q[1] - got_cyc_q[0] != FRAME) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", got_cyc_q[1] - got_cyc_q[0], FRAME); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL b2b_pkt: got no rx_valid want %h", e); end
      else begin
        p = got_q.pop_front(); c = got_cyc_q.pop_front();
        if (p !== e) begin n_bad++; $display("FAIL b2b_pkt: got %h want %h", p, e); end
        n_cmp++; if (c != ec) begin n_bad++; $display("FAIL b2b_latency: got cycle %0d want %0d", c, ec); end
      end
    end
    n_cmp++; if (rx_packet !== '0) begin n_bad++; $display("FAIL b2b_final: got %h want 0", rx_packet); end
    n_cmp++; if (pkt_count !== 8'(exp_count)) begin n_bad++; $display("FAIL b2b_pktcount: got %0d want %0d", pkt_count, exp_count); end
  endtask

  task automatic test_single_packet();
    int s, v0, e0, c, ec;
    bit ok;
    logic [PB-1:0] p, e;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(alt_pattern(), 1'b1, s);
    wait_valids(v0 + 1, LAT + 10, ok);
    repeat (CPB) align();
    n_cmp++; if (!ok || valid_cnt - v0 != 1) begin n_bad++; $display("FAIL single_count: got %0d pulses want 1", valid_cnt - v0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL single_pkt: got no rx_valid want %h", e); end
      else begin
        p = got_q.pop_front(); c = got_cyc_q.pop_front();
        if (p !== e) begin n_bad++; $display("FAIL single_pkt: got %h want %h", p, e); end
        n_cmp++; if (c != ec) begin n_bad++; $display("FAIL single_latency: got cycle %0d want %0d", c, ec); end
      end
    end
    n_cmp++; if (rx_packet !== last_good) begin n_bad++; $display("FAIL single_hold: got %h want %h", rx_packet, last_good); end
    n_cmp++; if (pkt_count !== 8'(exp_count)) begin n_bad++; $display("FAIL single_pktcount: got %0d want %0d", pkt_count, exp_count); end
    n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL single_ferr: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_frame_error();
    int s, v0, e0;
    logic [PB-1:0] p;
    v0 = valid_cnt; e0 = err_cnt;
    p = rand_pkt();
    send_frame(p, 1'b0, s);
    repeat (500) @(posedge clk);
    #1;
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL ferr_count: got %0d pulses want 1", err_cnt - e0); end
    n_cmp++; if (err_cyc != s + LAT) begin n_bad++; $display("FAIL ferr_latency: got cycle %0d want %0d", err_cyc, s + LAT); end
    n_cmp++; if (valid_cnt != v0) begin n_bad++; $display("FAIL ferr_valid: got %0d pulses want 0", valid_cnt - v0); end
    n_cmp++; if (rx_packet !== last_good) begin n_bad++; $display("FAIL ferr_hold: got %h want %h", rx_packet, last_good); end
    n_cmp++; if (pkt_count !== 8'(exp_count)) begin n_bad++; $display("FAIL ferr_pktcount: got %0d want %0d", pkt_count, exp_count); end
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL ferr_waithi: got busy %b want 1", rx_busy); end
    rx_line = 1'b1;
    repeat (5) align();
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL ferr_release: got busy %b want 0", rx_busy); end
    n_cmp++; if (err_cnt - e0 != 1 || valid_cnt != v0) begin n_bad++; $display("FAIL ferr_retrigger: got %0d errs %0d valids want 1 and 0", err_cnt - e0, valid_cnt - v0); end
  endtask

  task automatic test_reset_mid();
    int ab, s, v0, c, ec;
    bit ok;
    logic [PB-1:0] p, e;
    ab = PB / 2;
    p = rand_pkt();
    rx_line = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = PB - 1; i >= PB - ab; i--) drive_bit(p[i]);
    rx_line = p[PB-1-ab];
    repeat (CPB / 2) @(posedge clk);
    #1;
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_inframe: got busy %b want 1", rx_busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_packet !== '0) begin n_bad++; $display("FAIL rstmid_packet: got %h want 0", rx_packet); end
    n_cmp++; if (pkt_count !== 8'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", pkt_count); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
    n_cmp++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_pulses: got valid %b ferr %b want 0 0", rx_valid, frame_err); end
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = '0; exp_count = 0;
    exp_q.delete(); exp_cyc_q.delete(); got_q.delete(); got_cyc_q.delete();
    v0 = valid_cnt;
    repeat (2 * FRAME) @(posedge clk);
    #1;
    n_cmp++; if (valid_cnt != v0) begin n_bad++; $display("FAIL rstmid_discard: got %0d pulses want 0", valid_cnt - v0); end
    send_frame(rand_pkt(), 1'b1, s);
    wait_valids(v0 + 1, LAT + 10, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL rstmid_pkt: got no rx_valid want %h", e); end
      else begin
        p = got_q.pop_front(); c = got_cyc_q.pop_front();
        if (p !== e) begin n_bad++; $display("FAIL rstmid_pkt: got %h want %h", p, e); end
        n_cmp++; if (c != ec) begin n_bad++; $display("FAIL rstmid_latency: got cycle %0d want %0d", c, ec); end
      end
    end
    n_cmp++; if (pkt_count !== 8'd1) begin n_bad++; $display("FAIL rstmid_pktcount: got %0d want 1", pkt_count); end
  endtask

  task automatic test_wrap();
    int s, v0, c, ec;
    bit ok;
    logic [PB-1:0] p, e;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0; last_good = '0;
    exp_q.delete(); exp_cyc_q.delete(); got_q.delete(); got_cyc_q.delete();
    align();
    v0 = valid_cnt;
    for (int k = 0; k < 255; k++) send_frame(rand_pkt(), 1'b1, s);
    wait_valids(v0 + 255, LAT + 10, ok);
    n_cmp++; if (pkt_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d want 255", pkt_count); end
    send_frame(rand_pkt(), 1'b1, s);
    wait_valids(v0 + 256, LAT + 10, ok);
    n_cmp++; if (!ok || valid_cnt - v0 != 256) begin n_bad++; $display("FAIL wrap_pulses: got %0d want 256", valid_cnt - v0); end
    n_cmp++; if (pkt_count !== 8'(exp_count)) begin n_bad++; $display("FAIL wrap_count: got %0d want %0d", pkt_count, exp_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      n_cmp++;
      if (got_q.size() == 0) begin n_bad++; $display("FAIL wrap_pkt: got no rx_valid want %h", e); end
      else begin
        p = got_q.pop_front(); c = got_cyc_q.pop_front();
        if (p !== e) begin n_bad++; $display("FAIL wrap_pkt: got %h want %h", p, e); end
        n_cmp++; if (c != ec) begin n_bad++; $display("FAIL wrap_latency: got cycle %0d want %0d", c, ec); end
      end
    end
    n_cmp++; if (rx_packet !== last_good) begin n_bad++; $display("FAIL wrap_last: got %h want %h", rx_packet, last_good); end
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL valid_ferr_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_back_to_back();
    test_single_packet();
    test_frame_error();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
